// File: rtl/fpu_stream_pkg.sv
// Shared FPU stream constants and types for the 1-to-2 demux and 2-to-1 mux.
package fpu_stream_pkg;

  localparam int FP_W        = 32;
  localparam int DEMUX_CNT_W = 16;

  // Output / input port index encoding, shared with the 2-to-1 operand mux.
  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  // One-entry holding slot occupancy.
  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/stream_demux_1to2_if.sv
// Handshake bundle for the 1-to-2 demux: one input stream, two output streams,
// plus the per-output delivered-word counters.
interface stream_demux_1to2_if #(
  parameter int W  = 32,
  parameter int CW = 16
);
  logic [W-1:0]  DIN;
  logic          DIN_SEL;
  logic          DIN_VALID;
  logic          DIN_READY;
  logic [W-1:0]  OUT0;
  logic          OUT0_VALID;
  logic          OUT0_READY;
  logic [W-1:0]  OUT1;
  logic          OUT1_VALID;
  logic          OUT1_READY;
  logic [CW-1:0] CNT0;
  logic [CW-1:0] CNT1;

  // Producer plus both consumers (the environment around the demux).
  modport master (
    output DIN, DIN_SEL, DIN_VALID, OUT0_READY, OUT1_READY,
    input  DIN_READY, OUT0, OUT0_VALID, OUT1, OUT1_VALID, CNT0, CNT1
  );

  // The demux itself.
  modport slave (
    input  DIN, DIN_SEL, DIN_VALID, OUT0_READY, OUT1_READY,
    output DIN_READY, OUT0, OUT0_VALID, OUT1, OUT1_VALID, CNT0, CNT1
  );
endinterface

// File: rtl/stream_demux_1to2_slot.sv
// One-entry output holding slot: data register, EMPTY/FULL state,
// load/drain handling and a wrapping delivered-word counter.
module demux_slot
  import fpu_stream_pkg::*;
#(
  parameter int W  = FP_W,
  parameter int CW = DEMUX_CNT_W
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          LOAD,
  input  logic [W-1:0]  LOAD_DATA,
  output logic [W-1:0]  DOUT,
  output logic          DOUT_VALID,
  input  logic          DOUT_READY,
  output logic [CW-1:0] CNT,
  output logic          FREE
);

  slot_state_e   state_q, state_d;
  logic [W-1:0]  data_q;
  logic [CW-1:0] cnt_q;
  logic          drain;

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) state_q <= SLOT_EMPTY;
    else     state_q <= state_d;
  end

  // Next state: a load wins over a drain so drain+refill keeps the slot full.
  always_comb begin
    state_d = state_q;
    if (LOAD)       state_d = SLOT_FULL;
    else if (drain) state_d = SLOT_EMPTY;
  end

  // Outputs: valid comes straight from state, never from DOUT_READY.
  always_comb begin
    DOUT_VALID = (state_q == SLOT_FULL);
    drain      = DOUT_VALID & DOUT_READY;
    FREE       = ~DOUT_VALID | DOUT_READY;
  end

  // Data register: captured on load, otherwise held (including across a drain).
  always_ff @(posedge CLK) begin
    if (RST)       data_q <= '0;
    else if (LOAD) data_q <= LOAD_DATA;
  end

  // Delivered-word counter, wraps silently.
  always_ff @(posedge CLK) begin
    if (RST)        cnt_q <= '0;
    else if (drain) cnt_q <= cnt_q + 1'b1;
  end

  assign DOUT = data_q;
  assign CNT  = cnt_q;

endmodule

// File: rtl/stream_demux_1to2.sv
// Registered 1-to-2 stream demux: steers each input word to one of two
// independently back-pressured holding slots chosen by DIN_SEL.
module stream_demux_1to2
  import fpu_stream_pkg::*;
#(
  parameter int W  = FP_W,
  parameter int CW = DEMUX_CNT_W
) (
  input  logic                  CLK,
  input  logic                  RST,
  stream_demux_1to2_if.slave    bus
);

  logic free0, free1;
  logic acc, load0, load1;

  // Ready reflects only the addressed slot, so a stalled consumer blocks
  // just the words aimed at it.
  always_comb begin
    bus.DIN_READY = ~RST & ((bus.DIN_SEL == PORT_B) ? free1 : free0);
    acc           = bus.DIN_VALID & bus.DIN_READY;
    load0         = acc & (bus.DIN_SEL == PORT_A);
    load1         = acc & (bus.DIN_SEL == PORT_B);
  end

  demux_slot #(.W(W), .CW(CW)) u_slot0 (
    .CLK        (CLK),
    .RST        (RST),
    .LOAD       (load0),
    .LOAD_DATA  (bus.DIN),
    .DOUT       (bus.OUT0),
    .DOUT_VALID (bus.OUT0_VALID),
    .DOUT_READY (bus.OUT0_READY),
    .CNT        (bus.CNT0),
    .FREE       (free0)
  );

  demux_slot #(.W(W), .CW(CW)) u_slot1 (
    .CLK        (CLK),
    .RST        (RST),
    .LOAD       (load1),
    .LOAD_DATA  (bus.DIN),
    .DOUT       (bus.OUT1),
    .DOUT_VALID (bus.OUT1_VALID),
    .DOUT_READY (bus.OUT1_READY),
    .CNT        (bus.CNT1),
    .FREE       (free1)
  );

endmodule

// File: tb/tb_stream_demux_1to2.sv
// Directed bench for stream_demux_1to2 (counter width 4 so wrap is reachable).
module tb_stream_demux_1to2;

  localparam int W  = 32;
  localparam int CW = 4;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  stream_demux_1to2_if #(.W(W), .CW(CW)) bus ();

  stream_demux_1to2 #(.W(W), .CW(CW)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.DIN        = '0;
    bus.DIN_SEL    = 1'b0;
    bus.DIN_VALID  = 1'b0;
    bus.OUT0_READY = 1'b1;
    bus.OUT1_READY = 1'b1;
  endtask

  task automatic do_reset;
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    idle_inputs();
    rst = 1'b1;
    bus.DIN       = 32'h3F800000;
    bus.DIN_VALID = 1'b1;
    for (int c = 0; c < 2; c++) begin
      step();
      checks++; if (bus.DIN_READY !== 1'b0) begin errors++; $display("FAIL rst_ready c%0d: got %b want 0", c, bus.DIN_READY); end
      checks++; if (bus.OUT0_VALID !== 1'b0) begin errors++; $display("FAIL rst_v0 c%0d: got %b want 0", c, bus.OUT0_VALID); end
      checks++; if (bus.OUT1_VALID !== 1'b0) begin errors++; $display("FAIL rst_v1 c%0d: got %b want 0", c, bus.OUT1_VALID); end
    end
    rst = 1'b0;
    bus.DIN_VALID = 1'b0;
    #1;
    checks++; if (bus.OUT0 !== 32'h0) begin errors++; $display("FAIL rst_out0: got %h want 0", bus.OUT0); end
    checks++; if (bus.OUT1 !== 32'h0) begin errors++; $display("FAIL rst_out1: got %h want 0", bus.OUT1); end
    checks++; if (bus.CNT0 !== 4'd0) begin errors++; $display("FAIL rst_cnt0: got %0d want 0", bus.CNT0); end
    checks++; if (bus.CNT1 !== 4'd0) begin errors++; $display("FAIL rst_cnt1: got %0d want 0", bus.CNT1); end
    checks++; if (bus.DIN_READY !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b want 1", bus.DIN_READY); end
  endtask

  task automatic test_single_route;
    do_reset();
    bus.DIN = 32'h40000000; bus.DIN_SEL = 1'b0; bus.DIN_VALID = 1'b1;
    #1;
    checks++; if (bus.DIN_READY !== 1'b1) begin errors++; $display("FAIL route_ready0: got %b want 1", bus.DIN_READY); end
    checks++; if (bus.OUT0_VALID !== 1'b0) begin errors++; $display("FAIL route_no_comb_path: got %b want 0", bus.OUT0_VALID); end
    step();
    bus.DIN = 32'h40400000; bus.DIN_SEL = 1'b1;
    #1;
    checks++; if (bus.OUT0_VALID !== 1'b1) begin errors++; $display("FAIL route_v0: got %b want 1", bus.OUT0_VALID); end
    checks++; if (bus.OUT0 !== 32'h40000000) begin errors++; $display("FAIL route_out0: got %h want 40000000", bus.OUT0); end
    checks++; if (bus.OUT1_VALID !== 1'b0) begin errors++; $display("FAIL route_v1_early: got %b want 0", bus.OUT1_VALID); end
    step();
    bus.DIN_VALID = 1'b0;
    #1;
    checks++; if (bus.OUT1_VALID !== 1'b1) begin errors++; $display("FAIL route_v1: got %b want 1", bus.OUT1_VALID); end
    checks++; if (bus.OUT1 !== 32'h40400000) begin errors++; $display("FAIL route_out1: got %h want 40400000", bus.OUT1); end
    checks++; if (bus.OUT0_VALID !== 1'b0) begin errors++; $display("FAIL route_v0_drained: got %b want 0", bus.OUT0_VALID); end
    checks++; if (bus.CNT0 !== 4'd1) begin errors++; $display("FAIL route_cnt0: got %0d want 1", bus.CNT0); end
    step();
    checks++; if (bus.CNT1 !== 4'd1) begin errors++; $display("FAIL route_cnt1: got %0d want 1", bus.CNT1); end
    checks++; if (bus.OUT1_VALID !== 1'b0) begin errors++; $display("FAIL route_v1_drained: got %b want 0", bus.OUT1_VALID); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] base;
    base = 32'h41000000;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      bus.DIN = base + 32'(i); bus.DIN_SEL = 1'b0; bus.DIN_VALID = 1'b1;
      #1;
      checks++; if (bus.DIN_READY !== 1'b1) begin errors++; $display("FAIL b2b_ready i%0d: got %b want 1", i, bus.DIN_READY); end
      if (i > 0) begin
        checks++; if (bus.OUT0_VALID !== 1'b1 || bus.OUT0 !== base + 32'(i - 1)) begin errors++; $display("FAIL b2b_out0 i%0d: got v%b %h want v1 %h", i, bus.OUT0_VALID, bus.OUT0, base + 32'(i - 1)); end
      end
      step();
    end
    bus.DIN_VALID = 1'b0;
    #1;
    checks++; if (bus.OUT0 !== 32'h41000007) begin errors++; $display("FAIL b2b_last: got %h want 41000007", bus.OUT0); end
    checks++; if (bus.CNT0 !== 4'd7) begin errors++; $display("FAIL b2b_cnt7: got %0d want 7", bus.CNT0); end
    step();
    checks++; if (bus.CNT0 !== 4'd8) begin errors++; $display("FAIL b2b_cnt8: got %0d want 8", bus.CNT0); end
    checks++; if (bus.OUT0_VALID !== 1'b0) begin errors++; $display("FAIL b2b_empty: got %b want 0", bus.OUT0_VALID); end
  endtask

  task automatic test_independent_stall;
    do_reset();
    bus.OUT1_READY = 1'b0;
    // A -> slot 1, held
    bus.DIN = 32'hAAAA0001; bus.DIN_SEL = 1'b1; bus.DIN_VALID = 1'b1;
    #1;
    checks++; if (bus.DIN_READY !== 1'b1) begin errors++; $display("FAIL stall_readyA: got %b want 1", bus.DIN_READY); end
    step();
    // B -> slot 0
    bus.DIN = 32'hBBBB0002; bus.DIN_SEL = 1'b0;
    #1;
    checks++; if (bus.DIN_READY !== 1'b1) begin errors++; $display("FAIL stall_readyB: got %b want 1", bus.DIN_READY); end
    checks++; if (bus.OUT1 !== 32'hAAAA0001 || bus.OUT1_VALID !== 1'b1) begin errors++; $display("FAIL stall_holdA1: got v%b %h want v1 aaaa0001", bus.OUT1_VALID, bus.OUT1); end
    step();
    // C -> slot 0 while B drains
    bus.DIN = 32'hCCCC0003;
    #1;
    checks++; if (bus.DIN_READY !== 1'b1) begin errors++; $display("FAIL stall_readyC: got %b want 1", bus.DIN_READY); end
    checks++; if (bus.OUT0 !== 32'hBBBB0002 || bus.OUT0_VALID !== 1'b1) begin errors++; $display("FAIL stall_outB: got v%b %h want v1 bbbb0002", bus.OUT0_VALID, bus.OUT0); end
    step();
    // D -> slot 1, blocked
    bus.DIN = 32'hDDDD0004; bus.DIN_SEL = 1'b1;
    #1;
    checks++; if (bus.DIN_READY !== 1'b0) begin errors++; $display("FAIL stall_readyD0: got %b want 0", bus.DIN_READY); end
    checks++; if (bus.OUT0 !== 32'hCCCC0003 || bus.OUT0_VALID !== 1'b1) begin errors++; $display("FAIL stall_outC: got v%b %h want v1 cccc0003", bus.OUT0_VALID, bus.OUT0); end
    checks++; if (bus.OUT1 !== 32'hAAAA0001) begin errors++; $display("FAIL stall_holdA2: got %h want aaaa0001", bus.OUT1); end
    step();
    #1;
    checks++; if (bus.DIN_READY !== 1'b0) begin errors++; $display("FAIL stall_readyD1: got %b want 0", bus.DIN_READY); end
    checks++; if (bus.OUT0_VALID !== 1'b0) begin errors++; $display("FAIL stall_v0_empty: got %b want 0", bus.OUT0_VALID); end
    checks++; if (bus.CNT0 !== 4'd2) begin errors++; $display("FAIL stall_cnt0: got %0d want 2", bus.CNT0); end
    checks++; if (bus.CNT1 !== 4'd0 || bus.OUT1 !== 32'hAAAA0001) begin errors++; $display("FAIL stall_holdA3: got cnt%0d %h want cnt0 aaaa0001", bus.CNT1, bus.OUT1); end
    bus.OUT1_READY = 1'b1;
    #1;
    checks++; if (bus.DIN_READY !== 1'b1) begin errors++; $display("FAIL stall_readyD2: got %b want 1", bus.DIN_READY); end
    step();
    bus.DIN_VALID = 1'b0;
    #1;
    checks++; if (bus.OUT1 !== 32'hDDDD0004 || bus.OUT1_VALID !== 1'b1) begin errors++; $display("FAIL stall_refillD: got v%b %h want v1 dddd0004", bus.OUT1_VALID, bus.OUT1); end
    checks++; if (bus.CNT1 !== 4'd1) begin errors++; $display("FAIL stall_cnt1a: got %0d want 1", bus.CNT1); end
    step();
    checks++; if (bus.CNT1 !== 4'd2 || bus.OUT1_VALID !== 1'b0) begin errors++; $display("FAIL stall_cnt1b: got cnt%0d v%b want cnt2 v0", bus.CNT1, bus.OUT1_VALID); end
  endtask

  task automatic test_mid_reset;
    do_reset();
    bus.OUT0_READY = 1'b0; bus.OUT1_READY = 1'b0;
    bus.DIN = 32'h12345678; bus.DIN_SEL = 1'b0; bus.DIN_VALID = 1'b1;
    step();
    bus.DIN = 32'h9ABCDEF0; bus.DIN_SEL = 1'b1;
    step();
    bus.DIN_VALID = 1'b0;
    #1;
    checks++; if (bus.OUT0_VALID !== 1'b1 || bus.OUT1_VALID !== 1'b1) begin errors++; $display("FAIL mrst_full: got v0=%b v1=%b want 1 1", bus.OUT0_VALID, bus.OUT1_VALID); end
    rst = 1'b1;
    #1;
    checks++; if (bus.DIN_READY !== 1'b0) begin errors++; $display("FAIL mrst_ready: got %b want 0", bus.DIN_READY); end
    step();
    rst = 1'b0;
    bus.OUT0_READY = 1'b1; bus.OUT1_READY = 1'b1;
    #1;
    checks++; if (bus.OUT0_VALID !== 1'b0 || bus.OUT1_VALID !== 1'b0) begin errors++; $display("FAIL mrst_cleared: got v0=%b v1=%b want 0 0", bus.OUT0_VALID, bus.OUT1_VALID); end
    checks++; if (bus.OUT0 !== 32'h0 || bus.OUT1 !== 32'h0) begin errors++; $display("FAIL mrst_data: got %h %h want 0 0", bus.OUT0, bus.OUT1); end
    for (int c = 0; c < 2; c++) begin
      step();
      checks++; if (bus.OUT0_VALID !== 1'b0 || bus.OUT1_VALID !== 1'b0 || bus.CNT0 !== 4'd0 || bus.CNT1 !== 4'd0) begin errors++; $display("FAIL mrst_discard c%0d: got v%b%b cnt%0d/%0d want v00 cnt0/0", c, bus.OUT0_VALID, bus.OUT1_VALID, bus.CNT0, bus.CNT1); end
    end
  endtask

  task automatic test_counter_wrap;
    logic [3:0] exp;
    do_reset();
    for (int i = 0; i < 17; i++) begin
      bus.DIN = 32'h50000000 + 32'(i); bus.DIN_SEL = 1'b1; bus.DIN_VALID = 1'b1;
      #1;
      exp = (i > 0) ? 4'(i - 1) : 4'd0;
      checks++; if (bus.CNT1 !== exp) begin errors++; $display("FAIL wrap_cnt i%0d: got %0d want %0d", i, bus.CNT1, exp); end
      step();
    end
    bus.DIN_VALID = 1'b0;
    #1;
    checks++; if (bus.CNT1 !== 4'd0) begin errors++; $display("FAIL wrap_zero: got %0d want 0", bus.CNT1); end
    step();
    checks++; if (bus.CNT1 !== 4'd1) begin errors++; $display("FAIL wrap_one: got %0d want 1", bus.CNT1); end
    checks++; if (bus.CNT0 !== 4'd0) begin errors++; $display("FAIL wrap_cnt0: got %0d want 0", bus.CNT0); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b1;
    idle_inputs();
    test_reset();
    test_single_route();
    test_back_to_back();
    test_independent_stall();
    test_mid_reset();
    test_counter_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
